// File: rtl/atm_account_arbiter.sv
// Two-terminal round-robin arbiter sequencing withdraw/deposit/query/exit against one balance.
// Optional ATM_TXN_LOG_EN adds saturating txn_count/err_count outputs.
module atm_account_arbiter #(
  parameter int unsigned      BAL_W    = 8,
  parameter int unsigned      AMT_W    = 6,
  parameter logic [BAL_W-1:0] INIT_BAL = BAL_W'(100)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [AMT_W-1:0] amt0,
  input  logic [AMT_W-1:0] amt1,
  output logic [1:0]       grant,
  output logic [1:0]       ack,
  output logic [1:0]       status,
  output logic [BAL_W-1:0] rsp_balance,
  output logic [BAL_W-1:0] balance,
`ifdef ATM_TXN_LOG_EN
  output logic [15:0]      txn_count,
  output logic [7:0]       err_count,
`endif
  output logic             busy
);

  localparam logic [1:0] OpWithdraw = 2'b00;
  localparam logic [1:0] OpDeposit  = 2'b01;
  localparam logic [1:0] StatOk     = 2'b00;
  localparam logic [1:0] StatNsf    = 2'b01;
  localparam logic [1:0] StatOvf    = 2'b10;
  localparam int unsigned PadW      = BAL_W + 1 - AMT_W;

  typedef enum logic [1:0] {StIdle, StGrant, StExec, StResp} state_e;

  state_e state_q, state_d;

  logic [1:0]       grant_q, grant_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       status_q, status_d;
  logic [BAL_W-1:0] rsp_q, rsp_d;
  logic [BAL_W-1:0] bal_q, bal_d;
  logic             winner_q, winner_d;
  logic             last_q, last_d;
  logic [1:0]       op_q, op_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic             win_sel;
  logic [BAL_W:0]   amt_ext, bal_ext, sum;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (|req) state_d = StGrant;
      StGrant: state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // On a tie the terminal that was not served last wins.
  always_comb begin
    unique case (req)
      2'b10:   win_sel = 1'b1;
      2'b11:   win_sel = ~last_q;
      default: win_sel = 1'b0;
    endcase
  end

  assign amt_ext = {{PadW{1'b0}}, amt_q};
  assign bal_ext = {1'b0, bal_q};
  assign sum     = bal_ext + amt_ext;

  // Output / datapath next-state logic
  always_comb begin
    grant_d  = grant_q;
    ack_d    = '0;
    status_d = '0;
    rsp_d    = '0;
    bal_d    = bal_q;
    winner_d = winner_q;
    last_d   = last_q;
    op_d     = op_q;
    amt_d    = amt_q;
    unique case (state_q)
      StIdle: begin
        grant_d = '0;
        if (|req) begin
          winner_d = win_sel;
          grant_d  = win_sel ? 2'b10 : 2'b01;
        end
      end
      StGrant: begin
        op_d  = winner_q ? op1 : op0;
        amt_d = winner_q ? amt1 : amt0;
      end
      StExec: begin
        ack_d  = grant_q;
        last_d = winner_q;
        unique case (op_q)
          OpWithdraw: begin
            if (amt_ext > bal_ext) status_d = StatNsf;
            else                   bal_d    = bal_q - amt_ext[BAL_W-1:0];
          end
          OpDeposit: begin
            if (sum[BAL_W]) status_d = StatOvf;
            else            bal_d    = sum[BAL_W-1:0];
          end
          default: status_d = StatOk;
        endcase
        rsp_d = bal_d;
      end
      StResp: grant_d = '0;
      default: grant_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q  <= '0;
      ack_q    <= '0;
      status_q <= '0;
      rsp_q    <= '0;
      bal_q    <= INIT_BAL;
      winner_q <= 1'b0;
      last_q   <= 1'b1;
      op_q     <= '0;
      amt_q    <= '0;
    end else begin
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      status_q <= status_d;
      rsp_q    <= rsp_d;
      bal_q    <= bal_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      op_q     <= op_d;
      amt_q    <= amt_d;
    end
  end

`ifdef ATM_TXN_LOG_EN
  logic [15:0] txn_q;
  logic [7:0]  err_q;

  // One update per transaction, while the response is presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txn_q <= '0;
      err_q <= '0;
    end else if (state_q == StResp) begin
      if (status_q != StatOk) begin
        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
      end else if (!op_q[1]) begin
        if (txn_q != 16'hFFFF) txn_q <= txn_q + 16'd1;
      end
    end
  end

  assign txn_count = txn_q;
  assign err_count = err_q;
`endif

  assign grant       = grant_q;
  assign ack         = ack_q;
  assign status      = status_q;
  assign rsp_balance = rsp_q;
  assign balance     = bal_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Directed bench for atm_account_arbiter: reset, single txn, ties, funds/overflow limits,
// reset during a transaction.
module tb_atm_account_arbiter;

  localparam int unsigned BAL_W = 8;
  localparam int unsigned AMT_W = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       req = '0;
  logic [1:0]       op0 = '0;
  logic [1:0]       op1 = '0;
  logic [AMT_W-1:0] amt0 = '0;
  logic [AMT_W-1:0] amt1 = '0;
  logic [1:0]       grant, ack, status;
  logic [BAL_W-1:0] rsp_balance, balance;
  logic             busy;
`ifdef ATM_TXN_LOG_EN
  logic [15:0]      txn_count;
  logic [7:0]       err_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  atm_account_arbiter #(
    .BAL_W   (BAL_W),
    .AMT_W   (AMT_W),
    .INIT_BAL(8'd100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .op0        (op0),
    .op1        (op1),
    .amt0       (amt0),
    .amt1       (amt1),
    .grant      (grant),
    .ack        (ack),
    .status     (status),
    .rsp_balance(rsp_balance),
    .balance    (balance),
`ifdef ATM_TXN_LOG_EN
    .txn_count  (txn_count),
    .err_count  (err_count),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Runs one transaction from IDLE; inputs must already be driven. Ends 1ns after E3.
  task automatic txn(input string name, input logic [1:0] exp_grant, input logic [1:0] exp_status,
                     input logic [BAL_W-1:0] exp_bal);
    @(posedge clk); #1;  // E0
    check({name, ".e0_grant"}, 32'(grant), 32'(exp_grant));
    check({name, ".e0_busy"}, 32'(busy), 32'd1);
    check({name, ".e0_ack"}, 32'(ack), 32'd0);
    @(posedge clk); #1;  // E1: latched, later edits must be ignored
    if (exp_grant[0]) begin op0 = ~op0; amt0 = ~amt0; end
    else              begin op1 = ~op1; amt1 = ~amt1; end
    check({name, ".e1_ack"}, 32'(ack), 32'd0);
    @(posedge clk); #1;  // E2
    check({name, ".e2_ack"}, 32'(ack), 32'(exp_grant));
    check({name, ".e2_grant"}, 32'(grant), 32'(exp_grant));
    check({name, ".e2_status"}, 32'(status), 32'(exp_status));
    check({name, ".e2_rsp"}, 32'(rsp_balance), 32'(exp_bal));
    check({name, ".e2_bal"}, 32'(balance), 32'(exp_bal));
    @(posedge clk); #1;  // E3
    check({name, ".e3_ack"}, 32'(ack), 32'd0);
    check({name, ".e3_grant"}, 32'(grant), 32'd0);
    check({name, ".e3_status"}, 32'(status), 32'd0);
    check({name, ".e3_rsp"}, 32'(rsp_balance), 32'd0);
    check({name, ".e3_busy"}, 32'(busy), 32'd0);
    req = req & ~exp_grant;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bal", 32'(balance), 32'd100);
`ifdef ATM_TXN_LOG_EN
    check("rst_txn", 32'(txn_count), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
`endif
    rst = 1'b1;
  endtask

  initial begin
    do_reset();

    // Single withdraw
    req = 2'b01; op0 = 2'b00; amt0 = 6'd30;
    txn("wd30", 2'b01, 2'b00, 8'd70);

    // Tie from reset: T0 first, then T1; repeated tie goes to T0 again
    do_reset();
    req = 2'b11; op0 = 2'b01; amt0 = 6'd20; op1 = 2'b00; amt1 = 6'd50;
    txn("tie1_t0", 2'b01, 2'b00, 8'd120);
    txn("tie1_t1", 2'b10, 2'b00, 8'd70);
    req = 2'b11; op0 = 2'b00; amt0 = 6'd20; op1 = 2'b10; amt1 = 6'd5;
    txn("tie2_t0", 2'b01, 2'b00, 8'd50);
    txn("tie2_t1q", 2'b10, 2'b00, 8'd50);

    // Insufficient funds
    req = 2'b10; op1 = 2'b00; amt1 = 6'd63;
    txn("nsf", 2'b10, 2'b01, 8'd50);

    // Build up to 230, then overflow, then fill to exactly 255
    req = 2'b01; op0 = 2'b01; amt0 = 6'd63;
    txn("dep63a", 2'b01, 2'b00, 8'd113);
    req = 2'b01; op0 = 2'b01; amt0 = 6'd63;
    txn("dep63b", 2'b01, 2'b00, 8'd176);
    req = 2'b01; op0 = 2'b01; amt0 = 6'd54;
    txn("dep54", 2'b01, 2'b00, 8'd230);
    req = 2'b01; op0 = 2'b01; amt0 = 6'd40;
    txn("ovf", 2'b01, 2'b10, 8'd230);
    req = 2'b01; op0 = 2'b01; amt0 = 6'd25;
    txn("dep25", 2'b01, 2'b00, 8'd255);

    // Exit leaves balance alone
    req = 2'b10; op1 = 2'b11; amt1 = 6'd9;
    txn("exit", 2'b10, 2'b00, 8'd255);
`ifdef ATM_TXN_LOG_EN
    check("log_txn", 32'(txn_count), 32'd7);
    check("log_err", 32'(err_count), 32'd2);
`endif

    // Reset while in EXEC discards the transaction
    req = 2'b01; op0 = 2'b00; amt0 = 6'd10;
    @(posedge clk); @(posedge clk); #1;
    check("mid_busy_exec", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_ack", 32'(ack), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_bal", 32'(balance), 32'd100);
    req = '0;
    @(posedge clk); #1;
    check("mid_ack_hold", 32'(ack), 32'd0);
    rst = 1'b1;
    req = 2'b01; op0 = 2'b00; amt0 = 6'd10;
    txn("post_rst", 2'b01, 2'b00, 8'd90);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
